// File: rtl/delay_line_var_if.sv
// Stream-side bundle of the variable delay line: control/select/sample inputs
// and the tapped sample, occupancy and select-error outputs.
interface delay_line_var_if #(
  parameter int SIG_DATA_WIDTH = 16,
  parameter int SEL_WIDTH      = 4
);
  logic                      Enable;
  logic                      Flush;
  logic [SEL_WIDTH-1:0]      Delay_Sel;
  logic                      Valid_In;
  logic [SIG_DATA_WIDTH-1:0] Data_In;
  logic                      Valid_Out;
  logic [SIG_DATA_WIDTH-1:0] Data_Out;
  logic [SEL_WIDTH-1:0]      Fill_Count;
  logic                      Sel_Err;

  modport master (
    output Enable, Flush, Delay_Sel, Valid_In, Data_In,
    input  Valid_Out, Data_Out, Fill_Count, Sel_Err
  );

  modport slave (
    input  Enable, Flush, Delay_Sel, Valid_In, Data_In,
    output Valid_Out, Data_Out, Fill_Count, Sel_Err
  );
endinterface

// File: rtl/delay_line_var.sv
// Runtime-selectable delay line: MAX_DELAY valid-qualified stages with stall,
// flush, occupancy count and a registered out-of-range select flag.
module delay_line_var #(
  parameter int SIG_DATA_WIDTH = 16,
  parameter int MAX_DELAY      = 8,
  parameter int SEL_WIDTH      = 4
) (
  input logic              clk,
  input logic              reset,
  delay_line_var_if.slave  bus
);
  localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(MAX_DELAY);

  logic [SIG_DATA_WIDTH-1:0] d_r [MAX_DELAY];
  logic [MAX_DELAY-1:0]      v_r;
  logic [SEL_WIDTH-1:0]      fill_r;
  logic                      sel_err_r;

  logic [SEL_WIDTH-1:0]      sel_eff_s;
  logic [SIG_DATA_WIDTH-1:0] din_gated_s;
  logic                      valid_out_s;
  logic [SIG_DATA_WIDTH-1:0] data_out_s;

  // Bubbles enter the pipe as zero data so Data_Out is zero whenever invalid.
  assign din_gated_s = bus.Valid_In ? bus.Data_In : {SIG_DATA_WIDTH{1'b0}};
  assign sel_eff_s   = (bus.Delay_Sel > MAX_SEL) ? MAX_SEL : bus.Delay_Sel;

  // Stage registers, valid bits and occupancy; flush outranks enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        d_r[i] <= {SIG_DATA_WIDTH{1'b0}};
      end
      v_r    <= {MAX_DELAY{1'b0}};
      fill_r <= {SEL_WIDTH{1'b0}};
    end else if (bus.Flush) begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        d_r[i] <= {SIG_DATA_WIDTH{1'b0}};
      end
      v_r    <= {MAX_DELAY{1'b0}};
      fill_r <= {SEL_WIDTH{1'b0}};
    end else if (bus.Enable) begin
      d_r[0] <= din_gated_s;
      v_r[0] <= bus.Valid_In;
      for (int i = 1; i < MAX_DELAY; i++) begin
        d_r[i] <= d_r[i-1];
        v_r[i] <= v_r[i-1];
      end
      // One sample in, the oldest stage out: net change is in minus out.
      fill_r <= fill_r + SEL_WIDTH'(bus.Valid_In) - SEL_WIDTH'(v_r[MAX_DELAY-1]);
    end
  end

  // Select error is sampled on every edge, independent of enable and flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= (bus.Delay_Sel > MAX_SEL);
    end
  end

  // Tap mux: zero select bypasses the stages; otherwise AND-OR over a one-hot hit.
  always_comb begin
    valid_out_s = 1'b0;
    data_out_s  = {SIG_DATA_WIDTH{1'b0}};
    if (sel_eff_s == {SEL_WIDTH{1'b0}}) begin
      valid_out_s = bus.Valid_In;
      data_out_s  = din_gated_s;
    end else begin
      for (int i = 0; i < MAX_DELAY; i++) begin
        valid_out_s = valid_out_s | ((sel_eff_s == SEL_WIDTH'(i + 1)) & v_r[i]);
        data_out_s  = data_out_s
                    | ({SIG_DATA_WIDTH{sel_eff_s == SEL_WIDTH'(i + 1)}} & d_r[i]);
      end
    end
  end

  assign bus.Valid_Out  = valid_out_s;
  assign bus.Data_Out   = data_out_s;
  assign bus.Fill_Count = fill_r;
  assign bus.Sel_Err    = sel_err_r;
endmodule

// File: doc/delay_line_var.md
# delay_line_var

Parametrised, runtime-selectable delay line for aligning data and control signals across pipeline branches of different depths, e.g. matching the bias/valid path to the MAC-tree latency in the conv and FC units. It generalises the fixed 3-cycle delay to any width and a maximum depth of `MAX_DELAY` stages. The tap can be selected at run time. Per-stage valid bits, a clock enable for pipeline stalls, a synchronous flush and an occupancy count are included.

## Interface
- `SIG_DATA_WIDTH`, default 16: width of the data path.
- `MAX_DELAY`, default 8: number of register stages, at least 1.
- `SEL_WIDTH`, default 4: width of `Delay_Sel` and `Fill_Count`. Must satisfy 2^SEL_WIDTH > MAX_DELAY.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `Enable`, input, 1: advances the pipeline when 1; holds all state when 0.
- `Flush`, input, 1: synchronous clear of all stages.
- `Delay_Sel`, input, SEL_WIDTH: requested delay in enabled cycles, range 0..MAX_DELAY.
- `Valid_In`, input, 1: qualifies `Data_In`.
- `Data_In`, input, SIG_DATA_WIDTH: input sample.
- `Valid_Out`, output, 1: qualifies `Data_Out`.
- `Data_Out`, output, SIG_DATA_WIDTH: delayed sample; zero whenever `Valid_Out` is 0.
- `Fill_Count`, output, SEL_WIDTH: number of stages currently holding valid data.
- `Sel_Err`, output, 1: registered flag, set when `Delay_Sel` > MAX_DELAY.

## Operation
- **Storage:** stage registers `D[0..MAX_DELAY-1]` (data) and `V[0..MAX_DELAY-1]` (valid).
- **Reset:** all `D`, `V`, `Fill_Count` and `Sel_Err` are cleared to 0.
  - Consequently `Valid_Out` = 0 and `Data_Out` = 0, except when `Delay_Sel` = 0 and `Valid_In` = 1 (combinational pass-through).
- **Shift:** on an edge with `Enable`=1 and `Flush`=0:
  - `D[0]` <= `Valid_In ? Data_In : 0`, and `V[0]` <= `Valid_In`.
  - `D[i]` <= `D[i-1]`, and `V[i]` <= `V[i-1]`.
  - Bubbles are stored as zero data.
- **Stall:** `Enable`=0 with `Flush`=0 leaves every stage register and `Fill_Count` unchanged.
- **Flush:** `Flush`=1 clears all `V`, `D` and `Fill_Count` on the edge. Flush has priority over `Enable`, and the `Data_In` present on that edge is discarded.
- **Tap selection** (combinational, from the effective select `S` = min(`Delay_Sel`, MAX_DELAY)):
  - `S`=0: `Valid_Out` = `Valid_In`, and `Data_Out` = `Valid_In ? Data_In : 0`.
  - `S`>0: `Valid_Out` = `V[S-1]`, and `Data_Out` = `D[S-1]`.
- **Changing `Delay_Sel` mid-stream** is allowed. The output switches to the new tap in the same cycle. Samples may be skipped or repeated; preventing that is the upstream controller's responsibility.
- **`Fill_Count`** (registered):
  - On a shift, it becomes `Fill_Count` + `Valid_In` − `V[MAX_DELAY-1]`, wrapped in SEL_WIDTH bits. The range never exceeds MAX_DELAY.
  - It is unaffected by `Delay_Sel`.
- **`Sel_Err`:** registered every edge, regardless of `Enable`, as (`Delay_Sel` > MAX_DELAY). Cleared by reset.

## Timing
- **Latency:** with `Delay_Sel`=N (1..MAX_DELAY) and `Enable` held at 1, a sample presented before edge k appears on `Data_Out` after edge k+N-1, i.e. N edges later.
- **Stalls:** under stalls, latency is N *enabled* edges. Stalled cycles add wall-clock latency but never drop or duplicate samples.
- **Zero delay:** `Delay_Sel`=0 gives zero latency (purely combinational path from `Data_In` to `Data_Out`).
- **Throughput:** one sample per enabled cycle. There is no back-pressure output; the block never blocks.
- **Reset mid-operation:** asynchronous assertion clears state immediately, not waiting for an edge. The first shift occurs on the first rising edge after deassertion with `Enable`=1.
- **Simultaneous `Flush` and `Valid_In`:** the flush wins, and `Fill_Count` is 0 after the edge.
- **Full occupancy:** with `Fill_Count` = MAX_DELAY and continuous valid input, `Fill_Count` stays at MAX_DELAY, because one sample enters as one leaves.

## Test plan
- **Latency sweep:** MAX_DELAY=8, `Enable`=1; drive `Valid_In`=1 with data 1, 2, 3, … for each `Delay_Sel` in 0..8.
  - `Data_Out` must equal the input from exactly `Delay_Sel` edges earlier.
  - Output must be 0 / invalid before the first sample arrives.
- **Stall:** `Delay_Sel`=3; feed 0xA1, 0xA2, 0xA3 and hold `Enable`=0 for 5 cycles mid-stream.
  - `Data_Out` sequence must be 0xA1, 0xA2, 0xA3 with no duplicates or losses.
  - `Fill_Count` must be constant during the stall.
- **Bubbles:** `Delay_Sel`=4; `Valid_In` pattern 1,0,1,1 with data 0x11, 0xFF, 0x22, 0x33.
  - `Valid_Out` must show 1,0,1,1 after 4 edges.
  - `Data_Out` must be 0x11, 0, 0x22, 0x33.
- **Flush:** fill all 8 stages (`Fill_Count`=8), then pulse `Flush` with `Valid_In`=1 and `Enable`=1.
  - Next cycle: `Fill_Count`=0 and `Valid_Out`=0 for any `Delay_Sel` ≥ 1.
- **Out-of-range select:** `Delay_Sel`=12 with MAX_DELAY=8.
  - Output must behave as delay 8.
  - `Sel_Err`=1 one edge later; it returns to 0 one edge after `Delay_Sel`=5.
- **Async reset mid-stream:** assert `reset` between edges while `Fill_Count`=5.
  - `Valid_Out`, `Data_Out` (`Delay_Sel`≥1), `Fill_Count` and `Sel_Err` must go to 0 before the next edge.
  - Streaming must resume cleanly after deassertion.
